div32u: RTL
===========

# div32u

Sequential unsigned 32-bit divider: the inverse companion of the shift-add unsigned multiplier. It computes a 32-bit quotient and a 32-bit remainder using one restoring shift-subtract step per clock, processing dividend bits MSB first. It shares the integer datapath with the multiplier and runs under a start/busy/done handshake, so the issuing stage can stall on `busy` and capture results on `done`.

## Interface
- No parameters; width is fixed at 32.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low; forces the block to the reset state immediately.
- `start`  in  1  request; sampled on `clk` rising edge, accepted only when `busy`=0.
- `op1`  in  32  dividend; captured on the accept edge.
- `op2`  in  32  divisor; captured on the accept edge.
- `quo`  out  32  quotient; registered.
- `rem`  out  32  remainder; registered.
- `busy`  out  1  high while a division is in progress.
- `done`  out  1  one-cycle pulse; `quo`/`rem` are valid in that cycle.
- `dbz`  out  1  divide-by-zero flag; valid with `done`, held until the next accept.

## Operation
- States: IDLE, RUN, DONE.
- Reset state: IDLE, and all of `quo`, `rem`, `busy`, `done`, `dbz` equal 0.
- IDLE or DONE with `start`=1:
  - Latch `op1` and `op2`.
  - Clear the partial remainder `r` (33 bits) and the counter `cnt` (5 bits).
  - If `op2`≠0, go to RUN.
  - If `op2`=0, go to DONE with `quo`=32'hFFFFFFFF, `rem`=op1, `dbz`=1.
- RUN, one step per cycle:
  - `t = {r[31:0], dvd[31]} - {1'b0, dvs}`, where `dvd` is the shifting dividend.
  - If `t[32]`=0: `r`=t and the quotient bit is 1. Otherwise `r` is shifted and unchanged, and the quotient bit is 0.
  - `dvd` shifts left by 1, and the quotient bit shifts into `q[0]`.
  - `cnt` increments. RUN → DONE when `cnt`=31 is processed.
- On entry to DONE: `quo`=q, `rem`=r[31:0], `done`=1 for exactly one cycle.
- DONE → IDLE on the next edge if `start`=0. `quo`, `rem` and `dbz` hold until the next accept.
- `start` while `busy`=1 is ignored: no queueing, no error.
- `op1`/`op2` may change freely after the accept edge; only the latched copies are used.
- Arithmetic rules:
  - All values are unsigned.
  - Invariant: `op1 = quo*op2 + rem` with `rem < op2` whenever `dbz`=0.
  - `r` needs 33 bits to hold the borrow.
- Assertion of `rst` in any state aborts the operation with no `done` pulse. Outputs return to their reset values asynchronously.

## Timing
- Accept on edge E0. `busy`=1 from E0 until edge E32. `done`=1 from E32 until E33. Latency is 32 cycles.
- Divide by zero: `busy` never rises, and `done`=1 from E1 until E2.
- Back-to-back: `start`=1 during the `done` cycle is accepted, so the next `done` follows 32 cycles later. Maximum throughput is one result per 32 cycles.
- Release of `rst` takes effect at the next `clk` edge. The first accept is possible on that edge.
- `busy` and `done` are never high together.

## Structure
- The width constant (32) and the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) go in a shared include alongside the other shared IPs.
- One sub-module is natural: `div_step`. It is combinational and takes `r[31:0]`, the incoming dividend bit and the divisor. It produces the next `r` and the quotient bit, and reuses the shared 64-bit adder with an inverted operand and carry-in 1.
- The top level holds the FSM, `cnt`, the `dvd`/`q`/`r`/`dvs` registers and the output registers.

## Test plan
- 100 / 7 → `done` 32 cycles after accept, `quo`=14, `rem`=2, `dbz`=0.
- 32'hFFFFFFFF / 1 → `quo`=32'hFFFFFFFF, `rem`=0. Also 5 / 9 → `quo`=0, `rem`=5.
- 1234 / 0 → `done` one cycle after accept, `quo`=32'hFFFFFFFF, `rem`=1234, `dbz`=1, `busy` stays 0.
- `start` pulsed again mid-RUN with different operands → ignored; original result delivered at E32. Then `start` held during the `done` cycle with 81/9 → `quo`=9, `rem`=0 at the following `done`.
- `rst` driven low at cycle 10 of a division → outputs 0 immediately, no `done`. A new 50/3 after release → `quo`=16, `rem`=2.
- 10,000 random operand pairs (including 32'h80000000 and equal operands) → `quo*op2+rem`==op1 and `rem`<op2 checked against a reference model.

Source files
------------

// File: rtl/div32u_pkg.sv
// Shared definitions for the unsigned 32-bit divider: datapath width, FSM
// state encodings and the common 64-bit adder used by the integer datapath.
package div32u_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shared integer adder; subtraction is done by inverting b and setting cin.
    function automatic logic [63:0] add64(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic        cin);
        return a + b + {63'b0, cin};
    endfunction

endpackage

// File: rtl/div32u_step.sv
// One restoring shift-subtract step: trial-subtracts the divisor from the
// shifted partial remainder and keeps the difference only when it does not borrow.
module div32u_step
    import div32u_pkg::*;
(
    input  logic [WIDTH-1:0] rin,
    input  logic             din,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rout,
    output logic             qbit
);

    logic [63:0]    sum;
    logic [WIDTH:0] t;
    logic [30:0]    unusedHi;

    // t[WIDTH] is the borrow; the accepted remainder is always below dvs,
    // so it never needs more than WIDTH bits once the borrow is resolved.
    always_comb begin
        sum             = add64({31'b0, rin, din}, ~{32'b0, dvs}, 1'b1);
        {unusedHi, t}   = sum;
        qbit            = ~t[WIDTH];
        rout            = t[WIDTH] ? {rin[WIDTH-2:0], din} : t[WIDTH-1:0];
    end

endmodule

// File: rtl/div32u.sv
// Sequential unsigned 32-bit restoring divider with a start/busy/done
// handshake; one quotient bit per clock, MSB first, 32-cycle latency.
module div32u
    import div32u_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    state_t           state;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             zeroPend;
    logic [WIDTH-1:0] rNext;
    logic             qBit;

    div32u_step u_step (
        .rin  (r),
        .din  (dvd[WIDTH-1]),
        .dvs  (dvs),
        .rout (rNext),
        .qbit (qBit)
    );

    // A zero divisor skips RUN; zeroPend delays its done pulse by one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            q        <= '0;
            r        <= '0;
            zeroPend <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dbz      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (zeroPend) begin
                        done     <= 1'b1;
                        zeroPend <= 1'b0;
                    end else if (start) begin
                        dvd <= op1;
                        dvs <= op2;
                        r   <= '0;
                        q   <= '0;
                        cnt <= '0;
                        dbz <= (op2 == '0);
                        if (op2 != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state    <= DONE;
                            quo      <= '1;
                            rem      <= op1;
                            zeroPend <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    r   <= rNext;
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    q   <= {q[WIDTH-2:0], qBit};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        quo   <= {q[WIDTH-2:0], qBit};
                        rem   <= rNext;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
